// File: rtl/passcode_fsm.sv
// Passcode lock control: conditions the enter/clear buttons, collects four digits,
// compares them against PASSCODE and holds PASS/FAIL, with a lockout after repeated failures.
module passcode_fsm #(
   parameter logic [15:0] PASSCODE        = 16'h1234,
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
   parameter logic [27:0] HOLD_CYCLES     = 28'd200_000_000,
   parameter logic [1:0]  MAX_FAILS       = 2'd3,
   parameter logic [3:0]  LOCK_MULT       = 4'd4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] digit,
   input  logic       enter,
   input  logic       clear,
   output logic [2:0] state,
   output logic       correct,
   output logic       show,
   output logic [1:0] fails
);

   typedef enum logic [2:0] {
      E0   = 3'b000,
      E1   = 3'b001,
      E2   = 3'b010,
      E3   = 3'b100,
      PASS = 3'b011,
      FAIL = 3'b111
   } state_t;

   // 32 bits covers LOCK_MULT (4b) times HOLD_CYCLES (28b) without overflow
   localparam logic [31:0] HOLD_LEN = {4'd0, HOLD_CYCLES};
   localparam logic [31:0] LOCK_LEN = {28'd0, LOCK_MULT} * HOLD_LEN;

   state_t      state_q, state_d;
   logic        enter_s1_q, enter_s1_d, enter_s2_q, enter_s2_d;
   logic        clear_s1_q, clear_s1_d, clear_s2_q, clear_s2_d;
   logic        enter_lvl_q, enter_lvl_d;
   logic [19:0] db_cnt_q, db_cnt_d;
   logic        press_q, press_d;
   logic [3:0]  digit_q, digit_d;
   logic        mismatch_q, mismatch_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] hold_limit;
   logic [1:0]  fails_q, fails_d;
   logic        correct_q, correct_d;
   logic        show_q, show_d;
   logic        digit_ok;

   function automatic logic [3:0] code_nibble(input state_t s);
      case (s)
         E0:      code_nibble = PASSCODE[15:12];
         E1:      code_nibble = PASSCODE[11:8];
         E2:      code_nibble = PASSCODE[7:4];
         default: code_nibble = PASSCODE[3:0];
      endcase
   endfunction

   function automatic logic [1:0] fails_inc(input logic [1:0] f);
      fails_inc = (f >= MAX_FAILS) ? MAX_FAILS : f + 2'd1;
   endfunction

   // Input conditioning: synchronisers, then debounce of enter into a press pulse
   always_comb begin
      enter_s1_d  = enter;
      enter_s2_d  = enter_s1_q;
      clear_s1_d  = clear;
      clear_s2_d  = clear_s1_q;
      digit_d     = digit;
      enter_lvl_d = enter_lvl_q;
      db_cnt_d    = '0;
      press_d     = 1'b0;
      if (enter_s2_q != enter_lvl_q) begin
         if (db_cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
            enter_lvl_d = enter_s2_q;
            press_d     = enter_s2_q;
         end else begin
            db_cnt_d = db_cnt_q + 20'd1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      mismatch_d = mismatch_q;
      fails_d    = fails_q;
      hold_d     = '0;
      hold_limit = (fails_q == MAX_FAILS) ? LOCK_LEN : HOLD_LEN;
      digit_ok   = (digit_q == code_nibble(state_q));
      case (state_q)
         E0: begin
            if (press_q) begin
               mismatch_d = mismatch_q | ~digit_ok;
               state_d    = E1;
            end
         end
         E1, E2: begin
            if (clear_s2_q) begin
               state_d    = E0;
               mismatch_d = 1'b0;
            end else if (press_q) begin
               mismatch_d = mismatch_q | ~digit_ok;
               state_d    = (state_q == E1) ? E2 : E3;
            end
         end
         E3: begin
            if (clear_s2_q) begin
               state_d    = E0;
               mismatch_d = 1'b0;
            end else if (press_q) begin
               mismatch_d = 1'b0;
               if (!mismatch_q && digit_ok) begin
                  state_d = PASS;
                  fails_d = 2'd0;
               end else begin
                  state_d = FAIL;
                  fails_d = fails_inc(fails_q);
               end
            end
         end
         PASS: begin
            hold_d = hold_q + 32'd1;
            if (hold_q == HOLD_LEN - 32'd1) begin
               state_d = E0;
            end
         end
         FAIL: begin
            hold_d = hold_q + 32'd1;
            if (hold_q == hold_limit - 32'd1) begin
               state_d = E0;
               // leaving a lockout forgives the failure history
               if (fails_q == MAX_FAILS) begin
                  fails_d = 2'd0;
               end
            end
         end
         default: state_d = E0;
      endcase
      correct_d = (state_d == PASS);
      show_d    = (state_d != E0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= E0;
         enter_s1_q  <= 1'b0;
         enter_s2_q  <= 1'b0;
         clear_s1_q  <= 1'b0;
         clear_s2_q  <= 1'b0;
         enter_lvl_q <= 1'b0;
         db_cnt_q    <= '0;
         press_q     <= 1'b0;
         digit_q     <= '0;
         mismatch_q  <= 1'b0;
         hold_q      <= '0;
         fails_q     <= '0;
         correct_q   <= 1'b0;
         show_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         enter_s1_q  <= enter_s1_d;
         enter_s2_q  <= enter_s2_d;
         clear_s1_q  <= clear_s1_d;
         clear_s2_q  <= clear_s2_d;
         enter_lvl_q <= enter_lvl_d;
         db_cnt_q    <= db_cnt_d;
         press_q     <= press_d;
         digit_q     <= digit_d;
         mismatch_q  <= mismatch_d;
         hold_q      <= hold_d;
         fails_q     <= fails_d;
         correct_q   <= correct_d;
         show_q      <= show_d;
      end
   end

   assign state   = state_q;
   assign correct = correct_q;
   assign show    = show_q;
   assign fails   = fails_q;

endmodule

// File: tb/tb_passcode_fsm.sv
// Directed bench for passcode_fsm with short debounce (4) and hold (16) times.
module tb_passcode_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] digit = 4'd0;
   logic       enter = 1'b0;
   logic       clear = 1'b0;
   logic [2:0] state;
   logic       correct;
   logic       show;
   logic [1:0] fails;
   int         n_pass = 0;
   int         n_total = 0;
   int         cnt;

   always #5 clk = ~clk;

   passcode_fsm #(
      .PASSCODE       (16'h1234),
      .DEBOUNCE_CYCLES(20'd4),
      .HOLD_CYCLES    (28'd16),
      .MAX_FAILS      (2'd3),
      .LOCK_MULT      (4'd4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .digit  (digit),
      .enter  (enter),
      .clear  (clear),
      .state  (state),
      .correct(correct),
      .show   (show),
      .fails  (fails)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Raise enter long enough to register one press; ends the cycle before the FSM reacts.
   task automatic press_start(input logic [3:0] d);
      digit = d;
      enter = 1'b1;
      tick(6);
      enter = 1'b0;
   endtask

   task automatic press(input logic [3:0] d);
      press_start(d);
      tick(8);
   endtask

   task automatic count_state(input logic [2:0] s, output int n);
      n = 0;
      while (state === s && n < 200) begin
         n++;
         tick(1);
      end
   endtask

   task automatic count_correct(output int n);
      n = 0;
      while (correct === 1'b1 && n < 200) begin
         n++;
         tick(1);
      end
   endtask

   initial begin
      tick(2);
      chk("rst_state", 32'(state), 32'(3'b000));
      chk("rst_correct", 32'(correct), 32'd0);
      chk("rst_show", 32'(show), 32'd0);
      chk("rst_fails", 32'(fails), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // correct code
      press(4'd1);
      chk("ok_e1", 32'(state), 32'(3'b001));
      chk("ok_show_e1", 32'(show), 32'd1);
      press(4'd2);
      chk("ok_e2", 32'(state), 32'(3'b010));
      press(4'd3);
      chk("ok_e3", 32'(state), 32'(3'b100));
      press_start(4'd4);
      tick(1);
      chk("ok_pass", 32'(state), 32'(3'b011));
      chk("ok_correct", 32'(correct), 32'd1);
      count_correct(cnt);
      chk("ok_hold_len", 32'(cnt), 32'd16);
      chk("ok_back_e0", 32'(state), 32'(3'b000));
      chk("ok_show_off", 32'(show), 32'd0);

      // wrong second digit
      press(4'd1);
      press(4'd9);
      press(4'd3);
      press_start(4'd4);
      tick(1);
      chk("bad_fail", 32'(state), 32'(3'b111));
      chk("bad_correct", 32'(correct), 32'd0);
      chk("bad_fails", 32'(fails), 32'd1);
      count_state(3'b111, cnt);
      chk("bad_hold_len", 32'(cnt), 32'd16);
      chk("bad_back_e0", 32'(state), 32'(3'b000));
      chk("bad_fails_kept", 32'(fails), 32'd1);

      // correct code after a failure clears fails; a press during PASS is ignored
      press(4'd1);
      press(4'd2);
      press(4'd3);
      press_start(4'd4);
      tick(1);
      chk("rec_pass", 32'(state), 32'(3'b011));
      chk("rec_fails0", 32'(fails), 32'd0);
      tick(5);
      enter = 1'b1;
      tick(4);
      enter = 1'b0;
      tick(4);
      chk("pass_ignore_press", 32'(state), 32'(3'b011));
      tick(3);
      chk("pass_exit_e0", 32'(state), 32'(3'b000));
      tick(4);

      // debounce: short pulse rejected, long pulse advances once
      digit = 4'd1;
      enter = 1'b1;
      tick(3);
      enter = 1'b0;
      tick(10);
      chk("db_short", 32'(state), 32'(3'b000));
      press(4'd1);
      chk("db_long", 32'(state), 32'(3'b001));

      // clear arriving in the same cycle as a press wins, and drops the mismatch
      press(4'd9);
      chk("clr_e2", 32'(state), 32'(3'b010));
      digit = 4'd3;
      enter = 1'b1;
      tick(4);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      tick(1);
      enter = 1'b0;
      tick(1);
      chk("clr_wins", 32'(state), 32'(3'b000));
      tick(7);
      press(4'd1);
      press(4'd2);
      press(4'd3);
      press_start(4'd4);
      tick(1);
      chk("clr_then_pass", 32'(state), 32'(3'b011));
      count_correct(cnt);
      chk("clr_pass_len", 32'(cnt), 32'd16);

      // lockout after three consecutive failures (first uses a hex digit)
      for (int k = 1; k <= 3; k++) begin
         press((k == 1) ? 4'hA : 4'd1);
         press(4'd2);
         press(4'd3);
         press_start(4'd5);
         tick(1);
         chk("lock_fail_state", 32'(state), 32'(3'b111));
         chk("lock_fails_cnt", 32'(fails), 32'(k));
         count_state(3'b111, cnt);
         chk("lock_hold_len", 32'(cnt), (k == 3) ? 32'd64 : 32'd16);
      end
      chk("lock_exit_e0", 32'(state), 32'(3'b000));
      chk("lock_fails_rst", 32'(fails), 32'd0);

      // asynchronous reset in the middle of entry
      press(4'd1);
      press(4'd2);
      press(4'd3);
      press_start(4'd9);
      tick(1);
      chk("pre_rst_fails", 32'(fails), 32'd1);
      count_state(3'b111, cnt);
      press(4'd1);
      press(4'd2);
      chk("pre_rst_e2", 32'(state), 32'(3'b010));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", 32'(state), 32'(3'b000));
      chk("arst_show", 32'(show), 32'd0);
      chk("arst_correct", 32'(correct), 32'd0);
      chk("arst_fails", 32'(fails), 32'd0);
      tick(1);
      rst_n = 1'b1;
      tick(2);
      chk("post_rst_e0", 32'(state), 32'(3'b000));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
